vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 126 ++++++++++++
 tb/tb_vga_timing.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : VGA raster timing generator. A clock divider produces a
//                one-clock pixel tick; column/row counters advance on that
//                tick, and sync/blank are decoded from the registered
//                position. A frame-done pulse and a frame counter mark the
//                end of each visible area.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        pixel_en,
    output logic [9:0]  col,
    output logic [9:0]  row,
    output logic        HS_n,
    output logic        VS_n,
    output logic        blank,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int C_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int C_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int C_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [C_DIV_W-1:0] C_DIV_LAST   = C_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]         C_H_LAST     = 10'(C_H_TOTAL - 1);
    localparam logic [9:0]         C_V_LAST     = 10'(C_V_TOTAL - 1);
    localparam logic [9:0]         C_H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0]         C_V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0]         C_H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0]         C_V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0]         C_HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]         C_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]         C_VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]         C_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [C_DIV_W-1:0] div_q,         div_d;
    logic [9:0]         col_q,         col_d;
    logic [9:0]         row_q,         row_d;
    logic               frame_done_q,  frame_done_d;
    logic [15:0]        frame_count_q, frame_count_d;

    logic               w_pixel_en;
    logic               w_div_wrap;
    logic               w_line_end;
    logic               w_frame_end;
    logic               w_last_visible;

    // Divider wrap: a single-clock divider has only one state and wraps
    // every clock; otherwise wrap at the last count (or any stray value
    // above it, so an uninitialised register recovers on its own).
    generate
        if (CLK_DIV > 1) begin : g_div_multi
            assign w_div_wrap = (div_q >= C_DIV_LAST);
        end else begin : g_div_single
            assign w_div_wrap = 1'b1;
        end
    endgenerate

    assign w_pixel_en     = (div_q == C_DIV_LAST);
    // Greater-or-equal keeps the counters in range even from an arbitrary
    // power-up value.
    assign w_line_end     = (col_q >= C_H_LAST);
    assign w_frame_end    = (row_q >= C_V_LAST);
    assign w_last_visible = (col_q == C_H_VIS_LAST) && (row_q == C_V_VIS_LAST);

    // Next-state computation for divider, raster position and frame markers.
    always_comb begin
        div_d         = w_div_wrap ? '0 : div_q + 1'b1;
        col_d         = col_q;
        row_d         = row_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        if (w_pixel_en) begin
            if (w_line_end) begin
                col_d = 10'd0;
                row_d = w_frame_end ? 10'd0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
            frame_done_d = w_last_visible;
        end
        frame_count_d = frame_count_q + {15'd0, frame_done_d};
    end

    // State registers; synchronous reset overrides all counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q         <= '0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            row_q         <= row_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pixel_en    = w_pixel_en;
    assign col         = col_q;
    assign row         = row_q;
    assign blank       = (col_q >= C_H_VIS) || (row_q >= C_V_VIS);
    assign HS_n        = ~((col_q >= C_HS_START) && (col_q < C_HS_END));
    assign VS_n        = ~((row_q >= C_VS_START) && (row_q < C_VS_END));
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Directed self-checking bench for vga_timing. Uses a reduced
//                raster (15x10, CLK_DIV 2 and 1) for whole-frame behaviour and
//                the default 800x525 raster for one full line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // Small raster, CLK_DIV=2: H 8/2/3/2 (15), V 6/1/2/1 (10)
    logic        a_pe, a_hs, a_vs, a_blank, a_fd;
    logic [9:0]  a_col, a_row;
    logic [15:0] a_fc;
    // Default raster, CLK_DIV=2
    logic        b_pe, b_hs, b_vs, b_blank, b_fd;
    logic [9:0]  b_col, b_row;
    logic [15:0] b_fc;
    // Small raster, CLK_DIV=1
    logic        c_pe, c_hs, c_vs, c_blank, c_fd;
    logic [9:0]  c_col, c_row;
    logic [15:0] c_fc;

    vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2)
    ) dut_a (
        .clock(clock), .reset(reset), .pixel_en(a_pe), .col(a_col), .row(a_row),
        .HS_n(a_hs), .VS_n(a_vs), .blank(a_blank), .frame_done(a_fd),
        .frame_count(a_fc)
    );

    vga_timing dut_b (
        .clock(clock), .reset(reset), .pixel_en(b_pe), .col(b_col), .row(b_row),
        .HS_n(b_hs), .VS_n(b_vs), .blank(b_blank), .frame_done(b_fd),
        .frame_count(b_fc)
    );

    vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(1)
    ) dut_c (
        .clock(clock), .reset(reset), .pixel_en(c_pe), .col(c_col), .row(c_row),
        .HS_n(c_hs), .VS_n(c_vs), .blank(c_blank), .frame_done(c_fd),
        .frame_count(c_fc)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Hold reset for two clocks, then release; the call returns at k=0.
    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        n_checks++; if (a_col !== 10'd0) begin n_fail++; $display("FAIL reset_col: got %0d expected 0", a_col); end
        n_checks++; if (a_row !== 10'd0) begin n_fail++; $display("FAIL reset_row: got %0d expected 0", a_row); end
        n_checks++; if (a_pe !== 1'b0) begin n_fail++; $display("FAIL reset_pe_div2: got %b expected 0", a_pe); end
        n_checks++; if (a_blank !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b expected 0", a_blank); end
        n_checks++; if (a_hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b expected 1", a_hs); end
        n_checks++; if (a_vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b expected 1", a_vs); end
        n_checks++; if (a_fd !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", a_fd); end
        n_checks++; if (a_fc !== 16'd0) begin n_fail++; $display("FAIL reset_fc: got %0d expected 0", a_fc); end
        n_checks++; if (c_pe !== 1'b1) begin n_fail++; $display("FAIL reset_pe_div1: got %b expected 1", c_pe); end
        n_checks++; if (b_col !== 10'd0 || b_row !== 10'd0) begin n_fail++; $display("FAIL reset_default_pos: got %0d,%0d expected 0,0", b_row, b_col); end
        reset = 1'b0;
    endtask

    // Default raster: pixel_en cadence, first column step, line wrap and
    // per-line sync/blank widths.
    task automatic test_line_default();
        int hs_low;
        int blank_low;
        hs_low    = 0;
        blank_low = 0;
        do_reset();
        for (int k = 1; k <= 1600; k++) begin
            tick(1);
            if (!b_hs) hs_low++;
            if (!b_blank) blank_low++;
            if (k <= 6) begin
                n_checks++; if (b_pe !== k[0]) begin n_fail++; $display("FAIL line_pe_k%0d: got %b expected %b", k, b_pe, k[0]); end
            end
            if (k == 2) begin
                n_checks++; if (b_col !== 10'd1) begin n_fail++; $display("FAIL line_col_after2: got %0d expected 1", b_col); end
            end
            if (k == 1599) begin
                n_checks++; if (b_col !== 10'd799 || b_row !== 10'd0) begin n_fail++; $display("FAIL line_last_pos: got %0d,%0d expected 0,799", b_row, b_col); end
            end
            if (k == 1600) begin
                n_checks++; if (b_col !== 10'd0 || b_row !== 10'd1) begin n_fail++; $display("FAIL line_wrap_pos: got %0d,%0d expected 1,0", b_row, b_col); end
            end
        end
        n_checks++; if (hs_low != 192) begin n_fail++; $display("FAIL line_hs_width: got %0d clocks expected 192", hs_low); end
        n_checks++; if (blank_low != 1280) begin n_fail++; $display("FAIL line_visible: got %0d clocks expected 1280", blank_low); end
    endtask

    // Small raster, two frames: sync/blank totals, frame_done timing,
    // frame counter and raster wrap.
    task automatic test_frame();
        int hs_low, vs_low, vis, pulses, k1, k2;
        hs_low = 0; vs_low = 0; vis = 0; pulses = 0; k1 = -1; k2 = -1;
        do_reset();
        for (int k = 1; k <= 600; k++) begin
            tick(1);
            if (k <= 300) begin
                if (!a_hs) hs_low++;
                if (!a_vs) vs_low++;
                if (!a_blank) vis++;
            end
            if (a_fd) begin
                pulses++;
                if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
            end
            if (k == 166) begin
                n_checks++; if (a_fc !== 16'd1) begin n_fail++; $display("FAIL frame_fc_with_pulse: got %0d expected 1", a_fc); end
            end
            if (k == 299) begin
                n_checks++; if (a_col !== 10'd14 || a_row !== 10'd9) begin n_fail++; $display("FAIL frame_last_pos: got %0d,%0d expected 9,14", a_row, a_col); end
            end
            if (k == 300) begin
                n_checks++; if (a_col !== 10'd0 || a_row !== 10'd0 || a_blank !== 1'b0) begin n_fail++; $display("FAIL frame_wrap: got %0d,%0d blank %b expected 0,0 blank 0", a_row, a_col, a_blank); end
            end
        end
        n_checks++; if (hs_low != 60) begin n_fail++; $display("FAIL frame_hs_total: got %0d expected 60", hs_low); end
        n_checks++; if (vs_low != 60) begin n_fail++; $display("FAIL frame_vs_total: got %0d expected 60", vs_low); end
        n_checks++; if (vis != 96) begin n_fail++; $display("FAIL frame_visible: got %0d expected 96", vis); end
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL frame_pulses: got %0d expected 2", pulses); end
        n_checks++; if (k1 != 166) begin n_fail++; $display("FAIL frame_done_first: got %0d expected 166", k1); end
        n_checks++; if (k2 != 466) begin n_fail++; $display("FAIL frame_done_second: got %0d expected 466", k2); end
        n_checks++; if (a_fc !== 16'd2) begin n_fail++; $display("FAIL frame_count_two: got %0d expected 2", a_fc); end
    endtask

    // One-clock reset mid-frame at (row 3, col 4) of the second frame.
    task automatic test_mid_reset();
        do_reset();
        tick(398);
        n_checks++; if (a_col !== 10'd4 || a_row !== 10'd3 || a_fc !== 16'd1) begin n_fail++; $display("FAIL midrst_pre: got %0d,%0d fc %0d expected 3,4 fc 1", a_row, a_col, a_fc); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_checks++; if (a_col !== 10'd0 || a_row !== 10'd0 || a_fd !== 1'b0 || a_fc !== 16'd0) begin n_fail++; $display("FAIL midrst_post: got %0d,%0d fd %b fc %0d expected 0,0 fd 0 fc 0", a_row, a_col, a_fd, a_fc); end
        tick(2);
        n_checks++; if (a_col !== 10'd1 || a_row !== 10'd0) begin n_fail++; $display("FAIL midrst_resume: got %0d,%0d expected 0,1", a_row, a_col); end
        tick(164);
        n_checks++; if (a_fd !== 1'b1 || a_fc !== 16'd1) begin n_fail++; $display("FAIL midrst_frame: got fd %b fc %0d expected fd 1 fc 1", a_fd, a_fc); end
    endtask

    // Frame counter preloaded to 0xFFFF wraps to 0 on the next frame.
    task automatic test_count_wrap();
        do_reset();
        tick(10);
        force dut_a.frame_count_q = 16'hFFFF;
        #2;
        release dut_a.frame_count_q;
        tick(1);
        n_checks++; if (a_fc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", a_fc); end
        tick(155);
        n_checks++; if (a_fd !== 1'b1 || a_fc !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got fd %b fc %h expected fd 1 fc 0000", a_fd, a_fc); end
    endtask

    // CLK_DIV=1: pixel_en always high, frame period of 150 clocks.
    task automatic test_clkdiv1();
        int zeros, pulses, k1, k2;
        zeros = 0; pulses = 0; k1 = -1; k2 = -1;
        do_reset();
        n_checks++; if (c_pe !== 1'b1) begin n_fail++; $display("FAIL div1_pe_start: got %b expected 1", c_pe); end
        for (int k = 1; k <= 300; k++) begin
            tick(1);
            if (c_pe !== 1'b1) zeros++;
            if (c_fd) begin
                pulses++;
                if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
            end
            if (k == 1) begin
                n_checks++; if (c_col !== 10'd1) begin n_fail++; $display("FAIL div1_col_step: got %0d expected 1", c_col); end
            end
        end
        n_checks++; if (zeros != 0) begin n_fail++; $display("FAIL div1_pe_const: got %0d low clocks expected 0", zeros); end
        n_checks++; if (pulses != 2 || k1 != 83 || k2 != 233) begin n_fail++; $display("FAIL div1_frame_period: got %0d pulses at %0d,%0d expected 2 at 83,233", pulses, k1, k2); end
        n_checks++; if (c_fc !== 16'd2) begin n_fail++; $display("FAIL div1_count: got %0d expected 2", c_fc); end
    endtask

    initial begin
        test_reset();
        test_line_default();
        test_frame();
        test_mid_reset();
        test_count_wrap();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
